// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined MIPS immediate extender, valid/ready on both sides, 2-entry skid buffer. Rev 1.0
// Optional transfer statistics (ext_count/neg_count) enabled by defining IMM_EXTEND_PIPE_STATS_EN.
`default_nettype none

module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXTEND_PIPE_STATS_EN
  ,
  output logic [31:0]      ext_count,
  output logic [31:0]      neg_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [OUT_W-1:0]   m_data, s_data;
  logic [1:0]         m_mode, s_mode;
  logic [OUT_W-1:0]   sext, ext_data;
  logic               in_fire, out_fire;
  logic               load_m_new, load_s, m_from_s;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = sext;
    case (in_mode)
      2'b00:   ext_data = sext;
      2'b01:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10:   ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: ext_data = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // Handshake outputs come from state only, never from the partner's valid/ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = m_data;
  assign out_mode  = m_mode;

  always_comb begin
    state_nxt  = state;
    load_m_new = 1'b0;
    load_s     = 1'b0;
    m_from_s   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt  = ONE;
          load_m_new = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_m_new = 1'b1;
        end else if (in_fire) begin
          state_nxt = FULL;
          load_s    = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_nxt = ONE;
          m_from_s  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= EMPTY;
      m_data <= '0;
      m_mode <= 2'b00;
      s_data <= '0;
      s_mode <= 2'b00;
    end else begin
      state <= state_nxt;
      if (load_m_new) begin
        m_data <= ext_data;
        m_mode <= in_mode;
      end else if (m_from_s) begin
        m_data <= s_data;
        m_mode <= s_mode;
      end
      if (load_s) begin
        s_data <= ext_data;
        s_mode <= in_mode;
      end
    end
  end

`ifdef IMM_EXTEND_PIPE_STATS_EN
  // Negative-ness travels with each entry so it is counted when the word leaves.
  logic in_neg, m_neg, s_neg;

  assign in_neg = in_imm[IN_W-1] && (in_mode[1] == in_mode[0]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_neg     <= 1'b0;
      s_neg     <= 1'b0;
      ext_count <= 32'd0;
      neg_count <= 32'd0;
    end else begin
      if (load_m_new) begin
        m_neg <= in_neg;
      end else if (m_from_s) begin
        m_neg <= s_neg;
      end
      if (load_s) begin
        s_neg <= in_neg;
      end
      if (out_fire) begin
        ext_count <= ext_count + 32'd1;
        if (m_neg) begin
          neg_count <= neg_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: queue-based reference model plus directed literal checks.
`default_nettype none

module tb_imm_extend_pipe;

  localparam int IW = 16;
  localparam int OW = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_imm = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [1:0]    out_mode;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [7:0]    s_in_imm = '0;
  logic [1:0]    s_in_mode = 2'b00;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic [15:0]   s_out_data;
  logic [1:0]    s_out_mode;

`ifdef IMM_EXTEND_PIPE_STATS_EN
  logic [31:0]   ext_count, neg_count, s_ext_count, s_neg_count;
`endif

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.IN_W(IW), .OUT_W(OW)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef IMM_EXTEND_PIPE_STATS_EN
    , .ext_count(ext_count), .neg_count(neg_count)
`endif
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut_small (
    .Clk(Clk), .Reset(Reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_mode(s_out_mode)
`ifdef IMM_EXTEND_PIPE_STATS_EN
    , .ext_count(s_ext_count), .neg_count(s_neg_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value of the immediate as a signed/unsigned integer, scaled, then taken modulo 2^ow.
  function automatic longint model_ext(int iw, int ow, longint imm, int mode);
    longint sv, r, modv;
    modv = longint'(1) << ow;
    sv   = ((imm >> (iw - 1)) & 1) != 0 ? imm - (longint'(1) << iw) : imm;
    case (mode)
      0:       r = sv;
      1:       r = imm;
      2:       r = imm * (longint'(1) << (ow - iw));
      default: r = sv * 4;
    endcase
    return r & (modv - 1);
  endfunction

  typedef struct {
    longint data;
    int     mode;
    bit     neg;
  } exp_t;

  exp_t   q[$];
  bit     mon_en = 1'b0;
  longint exp_ext = 0;
  longint exp_neg = 0;

  always @(negedge Clk) begin
    if (mon_en) begin
      exp_t e;
      check("occ_out_valid", out_valid, q.size() != 0);
      check("occ_in_ready", in_ready, q.size() < 2);
      if (out_valid && q.size() > 0) begin
        check("out_data", out_data, q[0].data);
        check("out_mode", out_mode, q[0].mode);
      end
`ifdef IMM_EXTEND_PIPE_STATS_EN
      check("ext_count", ext_count, exp_ext & 64'hFFFF_FFFF);
      check("neg_count", neg_count, exp_neg & 64'hFFFF_FFFF);
`endif
      if (Reset) begin
        q.delete();
        exp_ext = 0;
        exp_neg = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          exp_ext++;
          if (e.neg) exp_neg++;
        end
        if (in_valid && in_ready) begin
          e.data = model_ext(IW, OW, longint'(in_imm), int'(in_mode));
          e.mode = int'(in_mode);
          e.neg  = in_imm[IW-1] && (in_mode == 2'b00 || in_mode == 2'b11);
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [15:0] t1_imm [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
  logic [1:0]  t1_mode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] t1_exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC};
  logic [7:0]  t5_imm [3] = '{8'h80, 8'h80, 8'h7F};
  logic [1:0]  t5_mode[3] = '{2'b00, 2'b10, 2'b11};
  logic [15:0] t5_exp [3] = '{16'hFF80, 16'h8000, 16'h01FC};

  initial begin
    int sent;
    int cyc;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_mode", out_mode, 0);
    check("rst_small_valid", s_out_valid, 0);

    check("model_sext", model_ext(16, 32, 'h8001, 0), 'hFFFF8001);
    check("model_upper", model_ext(16, 32, 'h1234, 2), 'h12340000);
    check("model_branch", model_ext(16, 32, 'hFFFF, 3), 'hFFFFFFFC);
    check("model_small_br", model_ext(8, 16, 'h7F, 3), 'h01FC);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_imm   = t1_imm[i];
      in_mode  = t1_mode[i];
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, t1_exp[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 0);

    // Back-pressure fills the skid register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'h0001;
    in_mode   = 2'b00;
    tick();
    check("bp_ready_one", in_ready, 1);
    check("bp_data_one", out_data, 32'h1);
    in_imm = 16'h0002;
    tick();
    in_valid = 1'b0;
    check("bp_ready_full", in_ready, 0);
    check("bp_data_full", out_data, 32'h1);
    tick();
    check("bp_hold", out_data, 32'h1);
    out_ready = 1'b1;
    tick();
    check("bp_second", out_data, 32'h2);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Reset while FULL; the input offered during reset must vanish
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'h0003;
    tick();
    in_imm = 16'h0004;
    tick();
    check("rf_full", in_ready, 0);
    Reset   = 1'b1;
    in_imm  = 16'hABCD;
    in_mode = 2'b01;
    tick();
    Reset    = 1'b0;
    in_valid = 1'b0;
    check("rf_out_valid", out_valid, 0);
    check("rf_in_ready", in_ready, 1);
    check("rf_out_data", out_data, 0);
    check("rf_out_mode", out_mode, 0);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rf_no_ghost", out_valid, 0);
    end

    // Narrow instance
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_in_imm   = t5_imm[i];
      s_in_mode  = t5_mode[i];
      tick();
      check("small_valid", s_out_valid, 1);
      check("small_data", s_out_data, t5_exp[i]);
    end
    s_in_valid = 1'b0;

    // Randomised traffic against the queue model
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom % 4) != 0;
      in_imm    = IW'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom % 3) != 0;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    check("random_sent", sent, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("random_drain", out_valid, 0);

`ifdef IMM_EXTEND_PIPE_STATS_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("stat_rst_ext", ext_count, 0);
    check("stat_rst_neg", neg_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      case (i)
        0:       begin in_imm = 16'h8000; in_mode = 2'b00; end
        1:       begin in_imm = 16'h0001; in_mode = 2'b00; end
        2:       begin in_imm = 16'hFFFF; in_mode = 2'b00; end
        3:       begin in_imm = 16'h8234; in_mode = 2'b01; end
        default: begin in_imm = 16'h8000; in_mode = 2'b10; end
      endcase
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("stat_ext5", ext_count, 5);
    check("stat_neg2", neg_count, 2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("stat_clr_ext", ext_count, 0);
    check("stat_clr_neg", neg_count, 0);
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath.
- Takes an IN_W-bit immediate and a 2-bit mode, and produces an OUT_W-bit operand.
- Modes: sign-extend, zero-extend, upper-load (LUI), and sign-extend-shift-left-2 (branch offset).
- Sits between the decode stage and the ALU operand mux, with valid/ready handshakes on both sides and a 2-entry skid buffer so back-pressure never drops data.

Parameters:
- IN_W, 16, immediate input width; legal range 2..OUT_W-2.
- OUT_W, 32, output word width.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a valid immediate.
- in_ready  output  1  unit can accept an input this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch (sign, <<2).
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  OUT_W  extended operand.
- out_mode  output  2  mode that produced out_data, for debug and forwarding.

Behaviour:
- Transfer rule: a transfer occurs on a Clk edge when valid and ready are both 1 on that side. in_ready must not depend combinationally on in_valid. out_valid must not depend combinationally on out_ready.
- Arithmetic, computed combinationally from in_imm/in_mode and registered on acceptance:
  - 00: bits [IN_W-1:0] = in_imm; upper bits = in_imm[IN_W-1].
  - 01: upper bits = 0.
  - 10: bits [OUT_W-1:OUT_W-IN_W] = in_imm; lower bits = 0.
  - 11: the mode-00 result shifted left 2; the two LSBs are 0 and the top 2 bits are discarded (truncated to OUT_W).
- Storage: a main output register M plus a skid register S. Three states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE (M valid, S empty): out_valid=1, in_ready=1.
  - FULL (M and S valid): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + in transfer -> ONE; the result is loaded into M.
  - ONE + in transfer + out transfer -> ONE; M reloads with the new result.
  - ONE + in transfer, no out transfer -> FULL; the result goes to S.
  - ONE + out transfer only -> EMPTY.
  - FULL + out transfer -> ONE; M <= S. No input is accepted because in_ready=0.
  - FULL, no out transfer -> FULL; M and S hold.
- Latency: 1 cycle from input acceptance to out_valid when the unit is EMPTY. Throughput is 1 per cycle while out_ready=1.
- Ordering: strict FIFO. Data is never lost or duplicated.
- Hold rule: out_data and out_mode are stable while out_valid=1 and out_ready=0.
- Reset: in any state, Reset=1 at an edge gives:
  - state EMPTY; out_valid=0; in_ready=1;
  - out_data = 0; out_mode = 00;
  - S cleared.
  - An input presented during the Reset cycle is discarded.
- out_ready=1 while out_valid=0 has no effect.
- in_imm and in_mode are ignored whenever in_valid=0.

Optional Feature:
- Macro: IMM_EXTEND_PIPE_STATS_EN.
- When defined:
  - Extra output port ext_count (32-bit) counts output transfers.
  - Extra output port neg_count (32-bit) counts output transfers in mode 00 or 11 whose in_imm MSB was 1.
  - Both counters reset to 0 on Reset and wrap from 0xFFFFFFFF to 0.
- When undefined:
  - Neither port exists and no counter logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Defaults, out_ready=1. Inputs (0x8001, 00), (0x8001, 01), (0x1234, 10), (0xFFFF, 11) on consecutive cycles -> out_data 0xFFFF8001, 0x00008001, 0x12340000, 0xFFFFFFFC, one per cycle, each 1 cycle after acceptance.
- Back-pressure: out_ready=0. Push (0x0001, 00) then (0x0002, 00) -> in_ready drops to 0 after the 2nd acceptance and out_data holds 0x00000001. Raise out_ready -> outputs 0x00000001 then 0x00000002, then in_ready returns to 1.
- Random in_valid/out_ready toggling over 1000 random inputs -> output sequence matches a reference model exactly, in order, with no drops or duplicates.
- Reset asserted while FULL -> next cycle out_valid=0, in_ready=1, out_data=0. The input presented during Reset never appears at the output.
- IN_W=8, OUT_W=16: (0x80, 00) -> 0xFF80; (0x80, 10) -> 0x8000; (0x7F, 11) -> 0x01FC.
- With IMM_EXTEND_PIPE_STATS_EN: 5 transfers, 2 of them negative in mode 00 -> ext_count=5, neg_count=2. Then Reset -> both read 0.
